lsu_subword: RTL and testbench

- Load/store unit between the single-cycle datapath and the word-wide dmem. dmem has one whole-word write enable and no byte enables.
- Loads: extracts the addressed byte or half from the read word, then sign- or zero-extends it.
- SW: passes straight through to dmem.
- SB/SH: done as a 2-cycle read-modify-write, with stall asserted to the core for the first cycle.
- Drives dmem's clk/rst/WE/A/WD and consumes its combinational RD.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_data_align.sv | 48 ++++
 rtl/lsu_subword.sv | 130 +++++++++++++
 tb/tb_lsu_subword.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the sub-word load/store unit.
//   - RV32I funct3 width/sign codes used by loads and stores
//   - FSM state type for the read-modify-write sequencer
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: purely combinational lane logic for the LSU.
//   mem_rd    in   32  word read from dmem
//   lane      in   2   byte address low bits (byte lane / half lane in bit 1)
//   funct3    in   3   RV32I width/sign code
//   wdata_lo  in   16  low store data bits (only these feed a sub-word merge)
//   load_data out  32  extracted and sign/zero-extended load value
//   merged    out  32  mem_rd with the addressed byte/half replaced
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane extraction followed by width/sign selection.
  always_comb begin
    byte_val  = mem_rd[{lane, 3'b000} +: 8];
    half_val  = lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_data = {24'h0, byte_val};
      F3_H:    load_data = {{16{half_val[15]}}, half_val};
      F3_HU:   load_data = {16'h0, half_val};
      F3_W:    load_data = mem_rd;
      default: load_data = '0;
    endcase
  end

  // Store merge: funct3[0] selects half vs byte. funct3[2] is not
  // meaningful for stores, so 100/101 behave like SB/SH here.
  always_comb begin
    merged = mem_rd;
    if (funct3[0]) begin
      merged[{lane[1], 4'b0000} +: 16] = wdata_lo;
    end else begin
      merged[{lane, 3'b000} +: 8] = wdata_lo[7:0];
    end
  end

endmodule

// File: rtl/lsu_subword.sv
// lsu_subword: load/store unit between the core and a word-wide dmem
// that has a single whole-word write enable.
//   Loads are extracted/extended combinationally from mem_rd.
//   SW writes straight through; SB/SH run a 2-cycle read-modify-write,
//   stalling the core during the read cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid, req_we   request strobe, 1 = store
//   funct3              width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata         byte address and store data
//   rdata               extended load result (combinational)
//   stall               core must hold this cycle
//   misaligned          access suppressed for illegal alignment
//   mem_we/mem_a/mem_wd to dmem; mem_rd from dmem (combinational)
// Build option: define LSU_MISALIGN_CHECK_EN to flag and suppress
// misaligned H/HU/SH and LW/SW; otherwise offending low bits are ignored.
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              misaligned,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("lsu_subword: DATA_W must be 32");
  end

  lsu_state_t        state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic              f3_legal;
  logic              is_word;
  logic              misalign_raw;
  logic              we_raw;

  assign word_addr = {addr[ADDR_W-1:2], 2'b00};
  assign f3_legal  = (funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                     (funct3 == F3_BU) || (funct3 == F3_HU);
  assign is_word   = (funct3[1:0] == 2'b10);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_raw = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        (is_word && (addr[1:0] != 2'b00));
`else
  assign misalign_raw = 1'b0;
`endif

  lsu_data_align u_align (
    .mem_rd    (mem_rd),
    .lane      (addr[1:0]),
    .funct3    (funct3),
    .wdata_lo  (wdata[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  // State and RMW capture registers. The merged word is captured on the
  // read cycle so the write cycle does not depend on core inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && (state_nx == RMW_WR)) begin
        addr_q <= word_addr;
        data_q <= merged;
      end
    end
  end

  // Next state and outputs. Everything is forced quiet while rst is high,
  // which also drops a pending RMW write.
  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    we_raw     = 1'b0;
    rdata      = '0;
    misaligned = 1'b0;
    mem_a      = word_addr;
    mem_wd     = wdata;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_valid && f3_legal) begin
            if (misalign_raw) begin
              misaligned = 1'b1;
            end else if (!req_we) begin
              rdata = load_data;
            end else if (is_word) begin
              we_raw = 1'b1;
            end else begin
              stall    = 1'b1;
              state_nx = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          mem_a    = addr_q;
          mem_wd   = data_q;
          we_raw   = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign mem_we = we_raw && !rst;

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: directed scoreboard bench for lsu_subword with a small
// behavioural dmem. Stimulus pushes per-cycle expectations; a monitor on the
// falling edge pops and compares them.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dmem [0:63];
  int          cycle = 0;
  int          tests = 0;
  int          errors = 0;
  bit          started = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        stall;
    logic        we;
    logic [31:0] wd;
    logic [31:0] a;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  lsu_subword dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, expv);
    end
  endtask

  task automatic applyStimulus(input string name, input logic r, input logic v,
                               input logic we, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] e_rdata, input logic e_stall,
                               input logic e_we, input logic [31:0] e_wd,
                               input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = wd;
    e.cyc = cycle; e.rdata = e_rdata; e.stall = e_stall; e.we = e_we;
    e.wd = e_wd; e.a = {a[31:2], 2'b00}; e.mis = e_mis;
    exp_q.push_back(e);
    name_q.push_back(name);
    started = 1'b1;
  endtask

  // Same as applyStimulus but for the write half of an RMW, where the
  // committed address comes from the earlier request, not the current inputs.
  task automatic applyRmwWrite(input string name, input logic [31:0] ra,
                               input logic [31:0] e_wd);
    applyStimulus(name, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0,
                  32'h0, 1'b0, 1'b1, e_wd, 1'b0);
    exp_q[exp_q.size()-1].a = ra;
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, "rdata", rdata, e.rdata);
      checkOutput(n, "stall", {31'b0, stall}, {31'b0, e.stall});
      checkOutput(n, "mem_we", {31'b0, mem_we}, {31'b0, e.we});
      checkOutput(n, "misaligned", {31'b0, misaligned}, {31'b0, e.mis});
      if (e.we) begin
        checkOutput(n, "mem_wd", mem_wd, e.wd);
        checkOutput(n, "mem_a", mem_a, e.a);
      end
    end else if (started) begin
      checkOutput("idle", "mem_we", {31'b0, mem_we}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    dmem[0] = 32'h2121_2121;
    dmem[1] = 32'h2323_2323;

    // Reset: a SW presented under reset must not write.
    applyStimulus("rst_sw", 1, 1, 1, 3'b010, 32'h1000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 3'b000, 32'h1000, 32'h0, 0, 0, 0, 0, 0);

    // Loads with sign/zero extension.
    applyStimulus("lb_1001", 0, 1, 0, 3'b000, 32'h1001, 0, 32'h0000_0021, 0, 0, 0, 0);
    applyStimulus("sw_1008", 0, 1, 1, 3'b010, 32'h1008, 32'h0000_80FF, 0, 0, 1, 32'h0000_80FF, 0);
    applyStimulus("lb_1008", 0, 1, 0, 3'b000, 32'h1008, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    applyStimulus("lbu_1008", 0, 1, 0, 3'b100, 32'h1008, 0, 32'h0000_00FF, 0, 0, 0, 0);
    applyStimulus("lh_1008", 0, 1, 0, 3'b001, 32'h1008, 0, 32'hFFFF_80FF, 0, 0, 0, 0);
    applyStimulus("lhu_1008", 0, 1, 0, 3'b101, 32'h1008, 0, 32'h0000_80FF, 0, 0, 0, 0);

    // SB via RMW; core inputs during the write cycle are junk.
    applyStimulus("sb_1002_rd", 0, 1, 1, 3'b000, 32'h1002, 32'h0000_00AA, 0, 1, 0, 0, 0);
    applyRmwWrite("sb_1002_wr", 32'h1000, 32'h21AA_2121);
    applyStimulus("lw_1000", 0, 1, 0, 3'b010, 32'h1000, 0, 32'h21AA_2121, 0, 0, 0, 0);

    // SH upper half, then SW single-cycle.
    applyStimulus("sh_1006_rd", 0, 1, 1, 3'b001, 32'h1006, 32'h1234_BEEF, 0, 1, 0, 0, 0);
    applyRmwWrite("sh_1006_wr", 32'h1004, 32'hBEEF_2323);
    applyStimulus("lw_1004a", 0, 1, 0, 3'b010, 32'h1004, 0, 32'hBEEF_2323, 0, 0, 0, 0);
    applyStimulus("sw_1004", 0, 1, 1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, 0);
    applyStimulus("lw_1004b", 0, 1, 0, 3'b010, 32'h1004, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);

    // Back-to-back SBs to the same word.
    applyStimulus("sw_restore", 0, 1, 1, 3'b010, 32'h1000, 32'h2121_2121, 0, 0, 1, 32'h2121_2121, 0);
    applyStimulus("sb_1000_rd", 0, 1, 1, 3'b000, 32'h1000, 32'h0000_0011, 0, 1, 0, 0, 0);
    applyRmwWrite("sb_1000_wr", 32'h1000, 32'h2121_2111);
    applyStimulus("sb_1003_rd", 0, 1, 1, 3'b000, 32'h1003, 32'h0000_0022, 0, 1, 0, 0, 0);
    applyRmwWrite("sb_1003_wr", 32'h1000, 32'h2221_2111);
    applyStimulus("lw_b2b", 0, 1, 0, 3'b010, 32'h1000, 0, 32'h2221_2111, 0, 0, 0, 0);

    // Reset during the RMW write cycle drops the write.
    applyStimulus("sb_rst_rd", 0, 1, 1, 3'b000, 32'h1000, 32'h0000_0033, 0, 1, 0, 0, 0);
    applyStimulus("sb_rst_wr", 1, 1, 1, 3'b000, 32'h1000, 32'h0000_0044, 0, 0, 0, 0, 0);
    applyStimulus("lb_after_rst", 0, 1, 0, 3'b000, 32'h1000, 0, 32'h0000_0011, 0, 0, 0, 0);
    applyStimulus("lw_after_rst", 0, 1, 0, 3'b010, 32'h1000, 0, 32'h2221_2111, 0, 0, 0, 0);

    // Misaligned accesses.
`ifdef LSU_MISALIGN_CHECK_EN
    applyStimulus("sw_1002", 0, 1, 1, 3'b010, 32'h1002, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
    applyStimulus("lw_mis_chk", 0, 1, 0, 3'b010, 32'h1000, 0, 32'h2221_2111, 0, 0, 0, 0);
    applyStimulus("lh_1001", 0, 1, 0, 3'b001, 32'h1001, 0, 32'h0, 0, 0, 0, 1);
`else
    applyStimulus("sw_1002", 0, 1, 1, 3'b010, 32'h1002, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, 0);
    applyStimulus("lw_mis_chk", 0, 1, 0, 3'b010, 32'h1000, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus("lh_1001", 0, 1, 0, 3'b001, 32'h1001, 0, 32'hFFFF_BEEF, 0, 0, 0, 0);
`endif

    // Reserved funct3 codes do nothing.
    applyStimulus("ld_f3_011", 0, 1, 0, 3'b011, 32'h1000, 0, 0, 0, 0, 0, 0);
    applyStimulus("st_f3_110", 0, 1, 1, 3'b110, 32'h1000, 32'h5555_5555, 0, 0, 0, 0, 0);
    applyStimulus("st_f3_111", 0, 1, 1, 3'b111, 32'h1004, 32'h5555_5555, 0, 0, 0, 0, 0);
    applyStimulus("lw_final", 0, 1, 0, 3'b010, 32'h1004, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    applyStimulus("idle_end", 0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
